// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-side definitions for the single-port memory arbiter.
// Holds the arbiter state encoding and the default starvation bound.
// Imported by mem_port_arbiter.

package mem_port_arbiter_pkg;

  // Arbiter FSM: idle, or the memory port owned by fetch or by the LSU.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GNT_IF  = 2'd1,
    ARB_GNT_LSU = 2'd2
  } type_arb_state_e;

  // Maximum consecutive LSU grants while a fetch is waiting.
  localparam int ARB_STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between fetch and LSU, LSU-first with bounded fetch starvation.
// Latency: grant registered in IDLE, mem_req_o rises next cycle; ack is combinational on mem_ack_i (min 2 cycles).
// Backpressure: requesters hold requests until acked; mem_* held until mem_ack_i; one idle bubble per transaction.

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEFAULT,
  parameter int CNT_W      = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_ack_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            lsu_req_i,
  input  logic            lsu_w_en_i,
  input  logic [3:0]      lsu_sel_byte_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  input  logic            lsu_flush_i,
  output logic            lsu_ack_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            mem_req_o,
  output logic            mem_w_en_o,
  output logic [3:0]      mem_sel_byte_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  type_arb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic             req_q, req_d;
  logic             w_en_q, w_en_d;
  logic [3:0]       sel_q, sel_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;

  logic starve;
  logic lsu_win;
  logic if_win;

  // Arbitration: LSU first unless fetch has waited through STARVE_MAX LSU grants.
  always_comb begin
    starve  = 1'b0;
    lsu_win = 1'b0;
    if_win  = 1'b0;
    if (state_q == ARB_IDLE) begin
      starve = if_req_i && (cnt_q == CNT_W'(STARVE_MAX));
      if (lsu_req_i && !lsu_flush_i && !starve) begin
        lsu_win = 1'b1;
      end else if (if_req_i) begin
        if_win = 1'b1;
      end
    end
  end

  // Next-state: latch the winner's request, hold it until mem_ack_i, track starvation and flush drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    req_d   = req_q;
    w_en_d  = w_en_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (lsu_win) begin
          state_d = ARB_GNT_LSU;
          req_d   = 1'b1;
          w_en_d  = lsu_w_en_i;
          sel_d   = lsu_sel_byte_i;
          addr_d  = lsu_addr_i;
          wdata_d = lsu_wdata_i;
          drop_d  = 1'b0;
          if (!if_req_i) begin
            cnt_d = '0;
          end else if (cnt_q != CNT_W'(STARVE_MAX)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (if_win) begin
          state_d = ARB_GNT_IF;
          req_d   = 1'b1;
          w_en_d  = 1'b0;
          sel_d   = 4'hF;
          addr_d  = if_addr_i;
          wdata_d = '0;
          cnt_d   = '0;
        end
      end
      ARB_GNT_IF: begin
        if (mem_ack_i) begin
          state_d = ARB_IDLE;
          req_d   = 1'b0;
          w_en_d  = 1'b0;
          sel_d   = 4'h0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      ARB_GNT_LSU: begin
        if (mem_ack_i) begin
          state_d = ARB_IDLE;
          req_d   = 1'b0;
          w_en_d  = 1'b0;
          sel_d   = 4'h0;
          addr_d  = '0;
          wdata_d = '0;
          drop_d  = 1'b0;
        end else if (lsu_flush_i) begin
          // The bus cannot abort: let the access finish but swallow its ack.
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and request registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      w_en_q  <= 1'b0;
      sel_q   <= 4'h0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
      w_en_q  <= w_en_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Completion routing: only the owner sees the ack; killed LSU accesses stay silent.
  always_comb begin
    if_ack_o    = (state_q == ARB_GNT_IF) && mem_ack_i;
    lsu_ack_o   = (state_q == ARB_GNT_LSU) && mem_ack_i && !drop_q && !lsu_flush_i;
    if_rdata_o  = if_ack_o ? mem_rdata_i : '0;
    lsu_rdata_o = lsu_ack_o ? mem_rdata_i : '0;
  end

  assign mem_req_o      = req_q;
  assign mem_w_en_o     = w_en_q;
  assign mem_sel_byte_o = sel_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple wait-state memory responder.
// Inputs change at posedge+2, outputs are checked at posedge+4.
// Every comparison goes through chk().

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        lsu_req_i;
  logic        lsu_w_en_i;
  logic [3:0]  lsu_sel_byte_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_flush_i;
  logic        lsu_ack_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o;
  logic        mem_w_en_o;
  logic [3:0]  mem_sel_byte_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  // Memory responder controls
  logic        mem_auto;
  logic        ack_auto;
  logic        ack_man;
  int          mem_wait;
  int          waited;

  int n_vec = 0;
  int n_err = 0;

  assign mem_ack_i = mem_auto ? ack_auto : ack_man;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .STARVE_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_w_en_i(lsu_w_en_i), .lsu_sel_byte_i(lsu_sel_byte_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_flush_i(lsu_flush_i),
    .lsu_ack_o(lsu_ack_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_w_en_o(mem_w_en_o), .mem_sel_byte_o(mem_sel_byte_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  // Memory model: acks after mem_wait request cycles have elapsed.
  initial begin
    ack_auto = 1'b0;
    waited   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req_o) begin
        if (waited >= mem_wait) begin
          ack_auto = 1'b1;
          waited   = 0;
        end else begin
          ack_auto = 1'b0;
          waited   = waited + 1;
        end
      end else begin
        ack_auto = 1'b0;
        waited   = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the drive point of the next cycle.
  task automatic drive_pt();
    @(posedge clk);
    #2;
  endtask

  // Move from drive point to sample point.
  task automatic sample_pt();
    #2;
  endtask

  task automatic idle_inputs();
    if_req_i       = 1'b0;
    if_addr_i      = '0;
    lsu_req_i      = 1'b0;
    lsu_w_en_i     = 1'b0;
    lsu_sel_byte_i = 4'h0;
    lsu_addr_i     = '0;
    lsu_wdata_i    = '0;
    lsu_flush_i    = 1'b0;
  endtask

  string seq;
  int    if_acks;
  int    lsu_acks;
  int    done;

  initial begin
    idle_inputs();
    rst_n       = 1'b0;
    mem_auto    = 1'b1;
    ack_man     = 1'b0;
    mem_wait    = 0;
    mem_rdata_i = '0;

    // ---------------- reset state
    drive_pt();
    drive_pt();
    sample_pt();
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_acks", {30'd0, if_ack_o, lsu_ack_o}, 32'd0);
    drive_pt();
    rst_n = 1'b1;
    drive_pt();

    // ---------------- IF-only fetch, one wait state
    mem_wait    = 1;
    mem_rdata_i = 32'h0000_0013;
    if_req_i    = 1'b1;
    if_addr_i   = 32'h0000_0100;
    sample_pt();
    chk("if1_req_not_comb", {31'd0, mem_req_o}, 32'd0);
    if_acks = 0;
    lsu_acks = 0;
    done = 0;
    for (int i = 0; i < 8 && done == 0; i++) begin
      drive_pt();
      sample_pt();
      if (mem_req_o) begin
        chk("if1_addr", mem_addr_o, 32'h0000_0100);
        chk("if1_wen_sel", {27'd0, mem_w_en_o, mem_sel_byte_o}, {27'd0, 1'b0, 4'hF});
      end
      if (lsu_ack_o) lsu_acks++;
      if (if_ack_o) begin
        if_acks++;
        chk("if1_rdata", if_rdata_o, 32'h0000_0013);
        done = 1;
      end
    end
    drive_pt();
    if_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_pt();
      if (if_ack_o) if_acks++;
      if (lsu_ack_o) lsu_acks++;
      drive_pt();
    end
    chk("if1_ack_count", if_acks, 32'd1);
    chk("if1_lsu_ack_count", lsu_acks, 32'd0);

    // ---------------- simultaneous IF + LSU store, zero-wait
    mem_wait       = 0;
    mem_rdata_i    = 32'h1234_5678;
    if_req_i       = 1'b1;
    if_addr_i      = 32'h0000_0200;
    lsu_req_i      = 1'b1;
    lsu_w_en_i     = 1'b1;
    lsu_sel_byte_i = 4'b0011;
    lsu_addr_i     = 32'h8000_0004;
    lsu_wdata_i    = 32'hDEAD_BEEF;
    sample_pt();
    chk("sim_c0_req", {31'd0, mem_req_o}, 32'd0);
    drive_pt();
    sample_pt();
    chk("sim_lsu_req", {31'd0, mem_req_o}, 32'd1);
    chk("sim_lsu_addr", mem_addr_o, 32'h8000_0004);
    chk("sim_lsu_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("sim_lsu_wen_sel", {27'd0, mem_w_en_o, mem_sel_byte_o}, {27'd0, 1'b1, 4'h3});
    chk("sim_lsu_acks", {30'd0, lsu_ack_o, if_ack_o}, {30'd0, 1'b1, 1'b0});
    drive_pt();
    lsu_req_i = 1'b0;
    sample_pt();
    chk("sim_bubble", {31'd0, mem_req_o}, 32'd0);
    drive_pt();
    sample_pt();
    chk("sim_if_addr", mem_addr_o, 32'h0000_0200);
    chk("sim_if_wen_sel", {27'd0, mem_w_en_o, mem_sel_byte_o}, {27'd0, 1'b0, 4'hF});
    chk("sim_if_ack", {30'd0, if_ack_o, lsu_ack_o}, {30'd0, 1'b1, 1'b0});
    chk("sim_if_rdata", if_rdata_o, 32'h1234_5678);
    chk("sim_lsu_rdata_zero", lsu_rdata_o, 32'd0);
    drive_pt();
    idle_inputs();

    // ---------------- starvation bound: continuous LSU, held IF
    drive_pt();
    if_req_i   = 1'b1;
    if_addr_i  = 32'h0000_0400;
    lsu_req_i  = 1'b1;
    lsu_w_en_i = 1'b0;
    lsu_sel_byte_i = 4'hF;
    lsu_addr_i = 32'h0000_0800;
    seq = "";
    for (int i = 0; i < 40 && seq.len() < 6; i++) begin
      sample_pt();
      if (mem_ack_i) begin
        if (if_ack_o) begin
          seq = {seq, "I"};
          chk("starve_cnt_after_if", {29'd0, dut.cnt_q}, 32'd0);
          chk("starve_if_addr", mem_addr_o, 32'h0000_0400);
        end else if (lsu_ack_o) begin
          seq = {seq, "L"};
        end else begin
          seq = {seq, "?"};
        end
      end
      drive_pt();
    end
    n_vec++;
    if (seq != "LLLLIL") begin
      n_err++;
      $display("FAIL starve_seq: got %s expected LLLLIL", seq);
    end
    idle_inputs();
    drive_pt();
    drive_pt();

    // ---------------- flush during a 3-wait-state LSU load
    mem_wait    = 3;
    mem_rdata_i = 32'hCAFE_0001;
    lsu_req_i   = 1'b1;
    lsu_w_en_i  = 1'b0;
    lsu_sel_byte_i = 4'hF;
    lsu_addr_i  = 32'h0000_0040;
    lsu_acks = 0;
    for (int c = 1; c <= 4; c++) begin
      drive_pt();
      if (c == 2) lsu_flush_i = 1'b1;
      if (c == 3) begin
        lsu_flush_i = 1'b0;
        lsu_req_i   = 1'b0;
      end
      sample_pt();
      chk("fl_req_held", {31'd0, mem_req_o}, 32'd1);
      chk("fl_addr_held", mem_addr_o, 32'h0000_0040);
      if (lsu_ack_o) lsu_acks++;
    end
    chk("fl_mem_ack_seen", {31'd0, mem_ack_i}, 32'd1);
    chk("fl_lsu_ack_suppressed", lsu_acks, 32'd0);
    drive_pt();
    sample_pt();
    chk("fl_req_dropped", {31'd0, mem_req_o}, 32'd0);
    // Next access arbitrates and completes normally
    mem_wait    = 0;
    mem_rdata_i = 32'hCAFE_0002;
    drive_pt();
    lsu_req_i = 1'b1;
    drive_pt();
    sample_pt();
    chk("fl_next_ack", {31'd0, lsu_ack_o}, 32'd1);
    chk("fl_next_rdata", lsu_rdata_o, 32'hCAFE_0002);
    drive_pt();
    lsu_req_i = 1'b0;

    // ---------------- flush coinciding with the ack
    drive_pt();
    lsu_req_i = 1'b1;
    drive_pt();
    lsu_flush_i = 1'b1;
    sample_pt();
    chk("flack_mem_ack", {31'd0, mem_ack_i}, 32'd1);
    chk("flack_lsu_ack", {31'd0, lsu_ack_o}, 32'd0);
    drive_pt();
    idle_inputs();

    // ---------------- flush in IDLE hands the slot to fetch
    drive_pt();
    lsu_req_i   = 1'b1;
    lsu_flush_i = 1'b1;
    lsu_addr_i  = 32'h0000_0900;
    if_req_i    = 1'b1;
    if_addr_i   = 32'h0000_0500;
    drive_pt();
    lsu_req_i   = 1'b0;
    lsu_flush_i = 1'b0;
    sample_pt();
    chk("idleflush_if_won", mem_addr_o, 32'h0000_0500);
    chk("idleflush_if_ack", {31'd0, if_ack_o}, 32'd1);
    drive_pt();
    idle_inputs();

    // ---------------- reset while GNT_LSU waits, then stray ack
    mem_wait   = 20;
    drive_pt();
    lsu_req_i  = 1'b1;
    lsu_addr_i = 32'h0000_0A00;
    drive_pt();
    sample_pt();
    chk("rstx_req_before", {31'd0, mem_req_o}, 32'd1);
    drive_pt();
    rst_n = 1'b0;
    lsu_req_i = 1'b0;
    drive_pt();
    sample_pt();
    chk("rstx_req_in_reset", {31'd0, mem_req_o}, 32'd0);
    chk("rstx_addr_in_reset", mem_addr_o, 32'd0);
    drive_pt();
    rst_n       = 1'b1;
    mem_auto    = 1'b0;
    ack_man     = 1'b1;
    mem_rdata_i = 32'hBAD0_BAD0;
    sample_pt();
    chk("rstx_stray_acks", {30'd0, if_ack_o, lsu_ack_o}, 32'd0);
    chk("rstx_stray_rdata", if_rdata_o | lsu_rdata_o, 32'd0);
    drive_pt();
    ack_man     = 1'b0;
    mem_auto    = 1'b1;
    mem_wait    = 0;
    mem_rdata_i = 32'h0000_0077;
    if_req_i    = 1'b1;
    if_addr_i   = 32'h0000_0300;
    sample_pt();
    chk("rstx_idle_after_stray", {31'd0, mem_req_o}, 32'd0);
    drive_pt();
    sample_pt();
    chk("rstx_if_addr", mem_addr_o, 32'h0000_0300);
    chk("rstx_if_ack", {31'd0, if_ack_o}, 32'd1);
    chk("rstx_if_rdata", if_rdata_o, 32'h0000_0077);
    drive_pt();
    idle_inputs();
    drive_pt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the fetch requester and the LSU data-bus requester.
- Used in single-port-memory builds, where instruction and data traffic reach one SRAM or bus slave.
- Sits between the pipeline's if2mem / lsu2dbus outputs and the memory.
- Registered grant, default priority to the LSU, bounded starvation of fetch, and flush-safe dropping of killed LSU responses.

Parameters:
- XLEN, 32, address/data width.
- STARVE_MAX, 4, max consecutive LSU grants issued while if_req_i is pending; must be >= 1.
- CNT_W, 3, width of starvation counter; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- if_req_i  in  1  fetch read request, held until if_ack_o
- if_addr_i  in  XLEN  fetch address
- if_ack_o  out  1  fetch response valid
- if_rdata_o  out  XLEN  fetch read data
- lsu_req_i  in  1  LSU request, held until lsu_ack_o or lsu_flush_i
- lsu_w_en_i  in  1  1 = store
- lsu_sel_byte_i  in  4  byte enables
- lsu_addr_i  in  XLEN  LSU address
- lsu_wdata_i  in  XLEN  store data
- lsu_flush_i  in  1  LSU access killed by pipeline flush
- lsu_ack_o  out  1  LSU response valid
- lsu_rdata_o  out  XLEN  load data
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_w_en_o  out  1  write enable
- mem_sel_byte_o  out  4  byte enables
- mem_addr_o  out  XLEN  address
- mem_wdata_o  out  XLEN  write data
- mem_ack_i  in  1  memory completion, single-cycle pulse
- mem_rdata_i  in  XLEN  read data, valid with mem_ack_i

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=IDLE, starvation counter=0, drop flag=0.
  - All mem_* outputs and both ack outputs are 0.
  - Reset mid-transaction abandons it; a late mem_ack_i in IDLE is ignored.
- States: IDLE, GNT_IF, GNT_LSU.
- IDLE arbitration, evaluated every cycle:
  - LSU wins if lsu_req_i & ~lsu_flush_i, unless if_req_i & (cnt == STARVE_MAX); then IF wins.
  - Otherwise IF wins if if_req_i.
  - The winner's request fields are latched into the mem_* registers. The next state is GNT_IF or GNT_LSU.
- mem_req_o=1 and mem_* are stable from the cycle after the grant until the mem_ack_i cycle inclusive. Request fields come from registers only, never combinationally from requesters.
- Fetch grants drive mem_w_en_o=0 and mem_sel_byte_o=4'hF.
- Completion (mem_ack_i=1 in GNT_x):
  - Owner's ack is asserted combinationally in that same cycle. rdata is passed through from mem_rdata_i.
  - Next state is IDLE; mem_req_o drops next cycle.
  - This gives one bubble cycle between transactions, so a held request is never re-granted twice.
- Non-owner ack is always 0. if_rdata_o and lsu_rdata_o equal mem_rdata_i only when their ack is high; otherwise 0.
- mem_ack_i in IDLE is ignored.
- Minimum latency from request to ack is 2 cycles with a zero-wait memory: grant at cycle N, ack at N+1.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on each LSU grant while if_req_i=1.
  - Clears on any IF grant, and on an LSU grant while if_req_i=0.
- Flush:
  - lsu_flush_i in IDLE suppresses LSU arbitration that cycle.
  - lsu_flush_i in GNT_LSU sets the drop flag. The memory transaction still completes, because the bus cannot abort, but lsu_ack_o is suppressed on its mem_ack_i.
  - The drop flag clears on that ack.
  - Flush coinciding with mem_ack_i in the same cycle also suppresses lsu_ack_o.
  - Flush has no effect in GNT_IF.
- Simultaneous requests in IDLE: LSU wins unless the starvation threshold has been reached.

Decomposition:
- Add to the shared memory defines package:
  - typedef enum logic [1:0] type_arb_state_e {ARB_IDLE, ARB_GNT_IF, ARB_GNT_LSU};
  - constant ARB_STARVE_MAX_DEFAULT = 4.
- No sub-module: the FSM, counter and output registers stay in one module. The arbitration decision is a local always_comb block.

Test Plan:
- IF-only request, addr 0x0000_0100, mem_ack_i one cycle after mem_req_o, rdata 0x0000_0013 -> mem_addr_o=0x100, mem_w_en_o=0, mem_sel_byte_o=F; if_ack_o pulses once with if_rdata_o=0x13; lsu_ack_o stays 0.
- Simultaneous IF (0x200) and LSU store (0x8000_0004, wdata 0xDEAD_BEEF, sel 4'b0011) -> LSU granted first with w_en=1 and sel=3; after its ack plus one bubble, IF is granted at 0x200.
- LSU requests continuously while IF is held high, zero-wait memory, STARVE_MAX=4 -> exactly 4 LSU grants, then 1 IF grant, then LSU again; counter reads 0 after the IF grant.
- LSU load in flight with mem_ack_i delayed 3 cycles; lsu_flush_i pulsed in the 2nd wait cycle -> mem_req_o held until ack; lsu_ack_o never asserted; next IDLE arbitrates normally.
- rst_n low while GNT_LSU waits, then stray mem_ack_i after reset release -> outputs 0 during reset; stray ack produces no if/lsu ack; next IF request proceeds normally.
